// File: rtl/ftdi_fifo_arbiter.sv
// ftdi_fifo_arbiter
//
// Sequences the FT232H asynchronous FIFO interface and shares the bidirectional
// 8-bit ADBUS between the host-read path (PC -> FPGA, feeds laser TX) and the
// host-write path (FPGA -> PC, fed by laser RX). Generates RD#/WR#, owns the
// ADBUS tri-state enable, inserts a bus turnaround gap after every transaction
// and alternates between directions when both are pending.
//
// Ports:
//   clock      system clock
//   reset      synchronous, active-high reset
//   en         1 = new transactions may start (in-flight ones always finish)
//   rxf        FTDI RXF#, active low: host byte available
//   txe        FTDI TXE#, active low: FTDI has space
//   adbus_in   ADBUS value from the pins
//   adbus_out  ADBUS drive value (registered)
//   adbus_tri  1 = FPGA drives ADBUS, 0 = high-Z (registered)
//   ftdi_rd    RD#, active low (registered)
//   ftdi_wr    WR#, active low (registered)
//   rx_data    byte read from the host (registered)
//   rx_valid   one-cycle pulse, rx_data valid (registered)
//   rx_ready   downstream can accept one byte
//   tx_data    byte to send to the host
//   tx_valid   tx_data pending; held until accepted
//   tx_ready   one-cycle accept pulse; tx_data captured this cycle (combinational)
//   busy       1 whenever the sequencer is not idle (registered)

module ftdi_fifo_arbiter #(
    parameter int unsigned RD_PULSE = 4,
    parameter int unsigned WR_SETUP = 2,
    parameter int unsigned WR_PULSE = 4,
    parameter int unsigned TURN     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic       rxf,
    input  logic       txe,
    input  logic [7:0] adbus_in,
    output logic [7:0] adbus_out,
    output logic       adbus_tri,
    output logic       ftdi_rd,
    output logic       ftdi_wr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy
);

    // Single shared down-counter, sized for the longest phase.
    localparam int unsigned MaxRw   = (RD_PULSE > WR_PULSE) ? RD_PULSE : WR_PULSE;
    localparam int unsigned MaxSt   = (WR_SETUP > TURN) ? WR_SETUP : TURN;
    localparam int unsigned MaxPar  = (MaxRw > MaxSt) ? MaxRw : MaxSt;
    localparam int unsigned CntW    = (MaxPar < 1) ? 1 : $clog2(MaxPar + 1);

    // Counter load values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CntW-1:0] RdLast  = CntW'(RD_PULSE - 1);
    localparam logic [CntW-1:0] SuLast  = CntW'(WR_SETUP - 1);
    localparam logic [CntW-1:0] WrLast  = CntW'(WR_PULSE - 1);
    localparam logic [CntW-1:0] TurnLast = CntW'(TURN - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    localparam logic GrantRead  = 1'b0;
    localparam logic GrantWrite = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StRdLow,
        StWrSetup,
        StWrLow,
        StWrHold,
        StTurn
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            last_grant_q;

    logic is_idle;
    logic rd_ok;
    logic wr_ok;
    logic grant_rd;
    logic grant_wr;

    // Eligibility is only meaningful in idle; folding is_idle in here keeps
    // tx_ready from ever pulsing mid-transaction.
    always_comb begin
        is_idle  = (state_q == StIdle);
        rd_ok    = is_idle & en & ~rxf & rx_ready;
        wr_ok    = is_idle & en & ~txe & tx_valid;
        // On contention, serve the direction that was not granted last.
        grant_rd = rd_ok & (~wr_ok | (last_grant_q == GrantWrite));
        grant_wr = wr_ok & (~rd_ok | (last_grant_q == GrantRead));
    end

    assign tx_ready = grant_wr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_grant_q <= GrantWrite;
            ftdi_rd      <= 1'b1;
            ftdi_wr      <= 1'b1;
            adbus_tri    <= 1'b0;
            adbus_out    <= 8'h00;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (grant_rd) begin
                        state_q      <= StRdLow;
                        cnt_q        <= RdLast;
                        last_grant_q <= GrantRead;
                        ftdi_rd      <= 1'b0;
                        busy         <= 1'b1;
                    end else if (grant_wr) begin
                        // Byte captured now so adbus_out is already stable on
                        // the first driven cycle and never changes until release.
                        state_q      <= StWrSetup;
                        cnt_q        <= SuLast;
                        last_grant_q <= GrantWrite;
                        adbus_out    <= tx_data;
                        adbus_tri    <= 1'b1;
                        busy         <= 1'b1;
                    end
                end

                StRdLow: begin
                    if (cnt_q == '0) begin
                        // Last low cycle: data has had the full pulse to settle.
                        rx_data  <= adbus_in;
                        rx_valid <= 1'b1;
                        ftdi_rd  <= 1'b1;
                        state_q  <= StTurn;
                        cnt_q    <= TurnLast;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end

                StWrSetup: begin
                    if (cnt_q == '0) begin
                        ftdi_wr <= 1'b0;
                        state_q <= StWrLow;
                        cnt_q   <= WrLast;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end

                StWrLow: begin
                    if (cnt_q == '0) begin
                        ftdi_wr <= 1'b1;
                        state_q <= StWrHold;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end

                StWrHold: begin
                    // Data held one cycle past WR# rising, then released.
                    adbus_tri <= 1'b0;
                    state_q   <= StTurn;
                    cnt_q     <= TurnLast;
                end

                StTurn: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end

                default: begin
                    // Unreachable encodings recover to a safe, released bus.
                    state_q   <= StIdle;
                    cnt_q     <= '0;
                    ftdi_rd   <= 1'b1;
                    ftdi_wr   <= 1'b1;
                    adbus_tri <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ftdi_fifo_arbiter.sv
// Self-checking bench for ftdi_fifo_arbiter with default parameters.
// A cycle table covers reset, a back-to-back read pair and a single write;
// hand-written sequences cover contention, gating and reset mid-transaction.

module tb_ftdi_fifo_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       en;
    logic       rxf;
    logic       txe;
    logic [7:0] adbus_in;
    logic [7:0] adbus_out;
    logic       adbus_tri;
    logic       ftdi_rd;
    logic       ftdi_wr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    ftdi_fifo_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .rxf       (rxf),
        .txe       (txe),
        .adbus_in  (adbus_in),
        .adbus_out (adbus_out),
        .adbus_tri (adbus_tri),
        .ftdi_rd   (ftdi_rd),
        .ftdi_wr   (ftdi_wr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy)
    );

    // Observed word: {rd, wr, drv, busy, rxv, txr, adbus_out, rx_data}
    logic [21:0] obs;
    assign obs = {ftdi_rd, ftdi_wr, adbus_tri, busy, rx_valid, tx_ready, adbus_out, rx_data};

    typedef struct {
        logic        rst;
        logic        en;
        logic        rxf;
        logic        txe;
        logic        rxr;
        logic        txv;
        logic [7:0]  ain;
        logic [7:0]  tdat;
        logic [21:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic e, input logic rf, input logic te,
                                input logic rr, input logic tv, input logic [7:0] ain,
                                input logic [7:0] tdat, input logic rd, input logic wr,
                                input logic drv, input logic bsy, input logic rxv,
                                input logic txr, input logic [7:0] aout, input logic [7:0] rxd);
        vec_t v;
        v.rst  = rst;
        v.en   = e;
        v.rxf  = rf;
        v.txe  = te;
        v.rxr  = rr;
        v.txv  = tv;
        v.ain  = ain;
        v.tdat = tdat;
        v.exp  = {rd, wr, drv, bsy, rxv, txr, aout, rxd};
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle_inputs();
        en       = 1'b1;
        rxf      = 1'b1;
        txe      = 1'b1;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
    endtask

    // Wait (bounded) for busy to drop; returns at posedge+1.
    task automatic wait_idle(input string name);
        int c;
        c = 0;
        @(negedge clock);
        while (busy && c < 40) begin
            @(negedge clock);
            c++;
        end
        check(name, 32'(busy), 32'd0);
        tick();
    endtask

    // Count cycles with any strobe low, busy or accept over n cycles.
    task automatic quiet_window(input string name, input int n);
        int viol;
        viol = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clock);
            if (!ftdi_rd || !ftdi_wr || busy || tx_ready || adbus_tri) viol++;
            tick();
        end
        check(name, 32'(viol), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        en       = 1'b1;
        rxf      = 1'b1;
        txe      = 1'b1;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        adbus_in = 8'h00;
        tx_data  = 8'h00;

        // rst en rxf txe rxr txv ain tdat | rd wr drv bsy rxv txr aout rxd
        // Reset then idle.
        add(1, 1, 1, 1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++)
            add(0, 1, 1, 1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
        // Read A5: grant in idle, 4 low cycles, rx_valid with RD# rising.
        add(0, 1, 0, 1, 1, 0, 8'hA5, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, 1, 1, 0, 8'hA5, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00, 8'h00);
        add(0, 1, 0, 1, 1, 0, 8'hA5, 8'h00, 1, 1, 0, 1, 1, 0, 8'h00, 8'hA5);
        add(0, 1, 0, 1, 1, 0, 8'hA5, 8'h00, 1, 1, 0, 1, 0, 0, 8'h00, 8'hA5);
        // Still pending: re-grant 7 cycles after the previous fall; then
        // withdraw rxf/rx_ready mid-pulse, read still completes with 5A.
        add(0, 1, 0, 1, 1, 0, 8'h5A, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00, 8'hA5);
        for (int i = 0; i < 4; i++)
            add(0, 1, 1, 1, 0, 0, 8'h5A, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00, 8'hA5);
        add(0, 1, 1, 1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1, 1, 0, 8'h00, 8'h5A);
        add(0, 1, 1, 1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1, 0, 0, 8'h00, 8'h5A);
        add(0, 1, 1, 1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00, 8'h5A);
        add(0, 1, 1, 1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00, 8'h5A);
        // Write 3C: accept pulse, 2 setup, 4 low, 1 hold, 2 turn.
        add(0, 1, 1, 0, 0, 1, 8'h00, 8'h3C, 1, 1, 0, 0, 0, 1, 8'h00, 8'h5A);
        for (int i = 0; i < 2; i++)
            add(0, 1, 1, 0, 0, 0, 8'h00, 8'hFF, 1, 1, 1, 1, 0, 0, 8'h3C, 8'h5A);
        for (int i = 0; i < 4; i++)
            add(0, 1, 1, 0, 0, 0, 8'h00, 8'hFF, 1, 0, 1, 1, 0, 0, 8'h3C, 8'h5A);
        add(0, 1, 1, 0, 0, 0, 8'h00, 8'hFF, 1, 1, 1, 1, 0, 0, 8'h3C, 8'h5A);
        for (int i = 0; i < 2; i++)
            add(0, 1, 1, 0, 0, 0, 8'h00, 8'hFF, 1, 1, 0, 1, 0, 0, 8'h3C, 8'h5A);
        add(0, 1, 1, 0, 0, 0, 8'h00, 8'hFF, 1, 1, 0, 0, 0, 0, 8'h3C, 8'h5A);

        repeat (3) @(posedge clock);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            reset    = vecs[i].rst;
            en       = vecs[i].en;
            rxf      = vecs[i].rxf;
            txe      = vecs[i].txe;
            rx_ready = vecs[i].rxr;
            tx_valid = vecs[i].txv;
            adbus_in = vecs[i].ain;
            tx_data  = vecs[i].tdat;
            @(negedge clock);
            check($sformatf("vec%0d", i), 32'(obs), 32'(vecs[i].exp));
            tick();
        end

        // Contention: both directions held pending; last grant was a write.
        begin
            int n_tr;
            int n_rd;
            int n_wr;
            int viol;
            int kind;
            logic prev_rd;
            logic accepted;
            logic [7:0] acc;
            n_tr    = 0;
            n_rd    = 0;
            n_wr    = 0;
            viol    = 0;
            prev_rd = 1'b1;
            acc     = 8'h3C;
            en       = 1'b1;
            rxf      = 1'b0;
            txe      = 1'b0;
            rx_ready = 1'b1;
            tx_valid = 1'b1;
            tx_data  = 8'h40;
            adbus_in = 8'h99;
            for (int c = 0; c < 400 && n_tr < 20; c++) begin
                @(negedge clock);
                if (!ftdi_rd && adbus_tri) viol++;
                if (!ftdi_rd && !ftdi_wr) viol++;
                if (adbus_tri && adbus_out !== acc) viol++;
                kind = tx_ready ? 1 : ((prev_rd && !ftdi_rd) ? 0 : 2);
                if (kind != 2) begin
                    check($sformatf("grant_order%0d", n_tr), 32'(kind), 32'(n_tr % 2));
                    if (kind == 0) n_rd++;
                    else n_wr++;
                    n_tr++;
                end
                prev_rd  = ftdi_rd;
                accepted = tx_ready;
                if (tx_ready) acc = tx_data;
                tick();
                if (accepted) tx_data = tx_data + 8'd1;
            end
            check("contention_total", 32'(n_tr), 32'd20);
            check("contention_reads", 32'(n_rd), 32'd10);
            check("contention_writes", 32'(n_wr), 32'd10);
            check("contention_invariants", 32'(viol), 32'd0);
        end
        set_idle_inputs();
        wait_idle("contention_drain");

        // Gating: read pending but rx_ready low.
        rxf = 1'b0;
        quiet_window("gate_rx_ready", 20);
        // Gating: en low with both sides pending.
        en       = 1'b0;
        rx_ready = 1'b1;
        txe      = 1'b0;
        tx_valid = 1'b1;
        quiet_window("gate_en", 20);

        // en dropped during WR_LOW: write finishes, nothing further starts.
        begin
            logic got;
            int nd;
            int nw;
            got      = 1'b0;
            nd       = 0;
            nw       = 0;
            en       = 1'b1;
            rxf      = 1'b1;
            rx_ready = 1'b0;
            tx_data  = 8'hC3;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clock);
                got = tx_ready;
                tick();
            end
            check("gate_wr_grant", 32'(got), 32'd1);
            rxf      = 1'b0;
            rx_ready = 1'b1;
            tx_data  = 8'h00;
            for (int c = 0; c < 30; c++) begin
                @(negedge clock);
                if (adbus_tri) nd++;
                if (!ftdi_wr) nw++;
                if (adbus_tri && adbus_out !== 8'hC3) nd = 100;
                if (!busy) break;
                if (nw == 2) en = 1'b0;
                tick();
            end
            check("gate_drive_len", 32'(nd), 32'd7);
            check("gate_wr_len", 32'(nw), 32'd4);
            check("gate_wr_done", 32'(busy), 32'd0);
            tick();
            quiet_window("gate_no_regrant", 20);
        end

        // Reset during the 2nd WR_LOW cycle.
        begin
            logic got;
            int nw;
            set_idle_inputs();
            rxf      = 1'b0;
            rx_ready = 1'b1;
            got      = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clock);
                got = !ftdi_rd;
                tick();
            end
            check("rst_pre_read", 32'(got), 32'd1);
            rxf      = 1'b1;
            rx_ready = 1'b0;
            wait_idle("rst_pre_read_done");

            txe      = 1'b0;
            tx_valid = 1'b1;
            tx_data  = 8'h77;
            got      = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clock);
                got = tx_ready;
                tick();
            end
            check("rst_pre_write", 32'(got), 32'd1);
            tx_valid = 1'b0;
            nw       = 0;
            for (int c = 0; c < 20 && nw < 2; c++) begin
                @(negedge clock);
                if (!ftdi_wr) nw++;
                if (nw < 2) tick();
            end
            check("rst_reached_wr_low", 32'(nw), 32'd2);
            reset = 1'b1;
            tick();
            reset    = 1'b0;
            rxf      = 1'b0;
            rx_ready = 1'b1;
            txe      = 1'b0;
            tx_valid = 1'b1;
            tx_data  = 8'h88;
            @(negedge clock);
            check("rst_wr_high", 32'(ftdi_wr), 32'd1);
            check("rst_bus_released", 32'(adbus_tri), 32'd0);
            check("rst_not_busy", 32'(busy), 32'd0);
            check("rst_first_grant_read", 32'(tx_ready), 32'd0);
            tick();
            @(negedge clock);
            check("rst_read_strobe", 32'(ftdi_rd), 32'd0);

            // Reset right after a read grant: contention must still pick READ.
            reset = 1'b1;
            tick();
            reset = 1'b0;
            @(negedge clock);
            check("rst2_idle", 32'({ftdi_rd, busy}), 32'b10);
            check("rst2_grant_read", 32'(tx_ready), 32'd0);
            tick();
            @(negedge clock);
            check("rst2_read_strobe", 32'(ftdi_rd), 32'd0);
            tick();
        end

        set_idle_inputs();
        wait_idle("final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
